// File: rtl/piece_bag_gen.sv
`default_nettype none
// ============================================================================
// Module      : piece_bag_gen
// Description : Piece generator with an LFSR source and a look-ahead queue.
//               The queue has PREVIEW_DEPTH+1 entries; entry 0 is the head.
//               Define PIECE_GEN_BAG_EN to draw pieces from a shuffled bag,
//               so every NUM_PIECES draws form a permutation. Leave it
//               undefined for plain random draws, where repeats can occur.
// Revision    : 1.0 - initial release
// ============================================================================
module piece_bag_gen #(
  parameter int                NUM_PIECES    = 7,
  parameter int                PIECE_W       = 3,
  parameter int                PREVIEW_DEPTH = 3,
  parameter int                LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] TAPS          = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED          = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               seed_load,
  input  logic [LFSR_W-1:0]                  seed,
  input  logic                               next_req,
  output logic [PIECE_W-1:0]                 piece,
  output logic                               piece_valid,
  output logic [PREVIEW_DEPTH*PIECE_W-1:0]   preview,
  output logic [$clog2(PREVIEW_DEPTH+2)-1:0] count
);

  localparam int                QD        = PREVIEW_DEPTH + 1;
  localparam int                CNT_W     = $clog2(PREVIEW_DEPTH + 2);
  localparam logic [7:0]        NP8       = 8'(NUM_PIECES);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  lfsr_step;
  logic [7:0]         cand_idx;
  logic [PIECE_W-1:0] cand;
  logic [PIECE_W-1:0] drawn;
  logic               pop;
  logic               push;
  logic [CNT_W-1:0]   tail;
  logic [CNT_W-1:0]   count_nxt;
  logic [0:0]         state;
  logic [PIECE_W-1:0] entries     [QD];
  logic [PIECE_W-1:0] entries_nxt [QD];

  // Galois step and candidate piece, both taken from the current LFSR value
  always_comb begin
    lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    cand_idx  = lfsr[7:0] % NP8;
    cand      = PIECE_W'(cand_idx) + PIECE_W'(1);
  end

  // LFSR advances every cycle unless a new seed is loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED_SAFE;
    end else if (seed_load) begin
      lfsr <= (seed == '0) ? LFSR_W'(1) : seed;
    end else begin
      lfsr <= lfsr_step;
    end
  end

`ifdef PIECE_GEN_BAG_EN
  logic [NUM_PIECES-1:0] used;
  logic [NUM_PIECES-1:0] drawn_oh;
  logic [NUM_PIECES-1:0] used_set;
  logic                  found;

  // Circular search from the candidate for the first code not yet drawn
  // from this bag. The mask never fills, so a free code always exists.
  always_comb begin
    drawn    = cand;
    drawn_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_PIECES; i++) begin
      for (int j = 0; j < NUM_PIECES; j++) begin
        if (!found && !used[j] && (((int'(cand_idx) + i) % NUM_PIECES) == j)) begin
          found       = 1'b1;
          drawn       = PIECE_W'(j + 1);
          drawn_oh[j] = 1'b1;
        end
      end
    end
    used_set = used | drawn_oh;
  end

  // Bag mask marks drawn codes and clears when the bag is complete
  always_ff @(posedge clk) begin
    if (rst) begin
      used <= '0;
    end else if (push) begin
      used <= (&used_set) ? '0 : used_set;
    end
  end
`else
  assign drawn = cand;
`endif

  // A pop always comes with a push, so occupancy only ever grows or holds
  always_comb begin
    pop       = next_req && (count != '0);
    push      = (state == ST_FILL) || pop;
    tail      = pop ? (count - CNT_W'(1)) : count;
    count_nxt = (push && !pop) ? (count + CNT_W'(1)) : count;
  end

  // Next queue contents: shift toward the head on pop, then write the tail
  always_comb begin
    for (int i = 0; i < QD; i++) begin
      entries_nxt[i] = entries[i];
    end
    if (pop) begin
      for (int i = 0; i < QD - 1; i++) begin
        entries_nxt[i] = entries[i + 1];
      end
      entries_nxt[QD-1] = '0;
    end
    for (int i = 0; i < QD; i++) begin
      if (push && (i == int'(tail))) begin
        entries_nxt[i] = drawn;
      end
    end
  end

  // Queue, occupancy and FILL/READY state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      state <= ST_FILL;
      for (int i = 0; i < QD; i++) begin
        entries[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      state <= (count_nxt == CNT_W'(QD)) ? ST_READY : ST_FILL;
      for (int i = 0; i < QD; i++) begin
        entries[i] <= entries_nxt[i];
      end
    end
  end

  assign piece       = entries[0];
  assign piece_valid = (count != '0);

  genvar k;
  generate
    for (k = 1; k <= PREVIEW_DEPTH; k++) begin : g_preview
      assign preview[(k-1)*PIECE_W +: PIECE_W] = entries[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_piece_bag_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_piece_bag_gen
// Description : Self-checking bench for piece_bag_gen (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piece_bag_gen;

  localparam int NP = 7;
  localparam int PW = 3;
  localparam int PD = 3;
  localparam int QD = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          seed_load;
  logic [15:0]   seed;
  logic          next_req;
  logic [PW-1:0] piece;
  logic          piece_valid;
  logic [PD*PW-1:0] preview;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0]   m_lfsr;
  logic [NP-1:0] m_used;
  int            m_q [QD];
  int            m_count;

  piece_bag_gen dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .next_req(next_req), .piece(piece), .piece_valid(piece_valid),
    .preview(preview), .count(count)
  );

  always #5 clk = ~clk;

  function automatic int m_draw(input logic [15:0] l, input logic [NP-1:0] used);
    int c;
    c = int'(l[7:0]) % NP;
`ifdef PIECE_GEN_BAG_EN
    for (int i = 0; i < NP; i++) begin
      if (!used[(c + i) % NP]) return ((c + i) % NP) + 1;
    end
`endif
    return c + 1;
  endfunction

  function automatic logic [PD*PW-1:0] m_preview();
    logic [PD*PW-1:0] p;
    p = '0;
    for (int k = 1; k <= PD; k++) p[(k-1)*PW +: PW] = PW'(m_q[k]);
    return p;
  endfunction

  // Drive one cycle of inputs, advance the model, then sample after the edge
  task automatic tick(input logic r, input logic sl, input logic [15:0] sd, input logic nr);
    int  d;
    bit  pop, push;
    rst = r; seed_load = sl; seed = sd; next_req = nr;
    if (r) begin
      m_lfsr = 16'hACE1; m_used = '0; m_count = 0;
      for (int i = 0; i < QD; i++) m_q[i] = 0;
    end else begin
      pop  = nr && (m_count > 0);
      push = (m_count < QD) || pop;
      if (push) begin
        d = m_draw(m_lfsr, m_used);
`ifdef PIECE_GEN_BAG_EN
        m_used[d-1] = 1'b1;
        if (&m_used) m_used = '0;
`endif
        if (pop) begin
          for (int i = 0; i < QD - 1; i++) m_q[i] = m_q[i+1];
          m_q[QD-1] = 0;
          m_count--;
        end
        m_q[m_count] = d;
        m_count++;
      end
      if (sl) m_lfsr = (sd == 16'h0) ? 16'h1 : sd;
      else    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (piece_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", piece_valid); end
    n_cmp++; if (piece !== 3'd0) begin n_err++; $display("FAIL reset_piece: got %0d want 0", piece); end
    n_cmp++; if (preview !== 9'd0) begin n_err++; $display("FAIL reset_preview: got %h want 0", preview); end
  endtask

  task automatic test_fill();
    logic [PD*PW-1:0] exp_prev;
`ifdef PIECE_GEN_BAG_EN
    exp_prev = {3'd4, 3'd3, 3'd1};
`else
    exp_prev = {3'd3, 3'd1, 3'd1};
`endif
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      tick(1'b0, 1'b0, 16'h0, 1'b0);
      n_cmp++;
      if (count !== CW'((e < 4) ? e : 4)) begin
        n_err++; $display("FAIL fill_count edge %0d: got %0d want %0d", e, count, (e < 4) ? e : 4);
      end
      n_cmp++;
      if (piece_valid !== 1'b1) begin n_err++; $display("FAIL fill_valid edge %0d: got %b want 1", e, piece_valid); end
    end
    n_cmp++; if (piece !== 3'd2) begin n_err++; $display("FAIL fill_head: got %0d want 2", piece); end
    n_cmp++; if (preview !== exp_prev) begin n_err++; $display("FAIL fill_preview: got %h want %h", preview, exp_prev); end
  endtask

  task automatic test_empty_req();
    tick(1'b1, 1'b0, 16'h0, 1'b1);
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_priority_count: got %0d want 0", count); end
    tick(1'b0, 1'b0, 16'h0, 1'b1);
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL empty_req_count: got %0d want 1", count); end
    n_cmp++; if (piece !== 3'd2) begin n_err++; $display("FAIL empty_req_piece: got %0d want 2", piece); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'b0, 16'h0, (i % 5) != 3);
      n_cmp++;
      if (piece !== PW'(m_q[0]) || preview !== m_preview() || count !== CW'(m_count)) begin
        n_err++; bad++;
        if (bad < 5) $display("FAIL b2b cycle %0d: got piece %0d prev %h cnt %0d want %0d %h %0d",
                              i, piece, preview, count, m_q[0], m_preview(), m_count);
      end
    end
  endtask

  task automatic test_seed();
    int run_a [20];
    int run_b [20];
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
    tick(1'b0, 1'b1, 16'h0000, 1'b0);
    n_cmp++; if (dut.lfsr !== 16'h0001) begin n_err++; $display("FAIL seed_zero: got %h want 0001", dut.lfsr); end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL seed_queue: got %0d want 4", count); end
    tick(1'b0, 1'b0, 16'h0, 1'b1);
`ifndef PIECE_GEN_BAG_EN
    n_cmp++; if (preview[8:6] !== 3'd2) begin n_err++; $display("FAIL seed_zero_tail: got %0d want 2", preview[8:6]); end
`endif
    n_cmp++; if (preview !== m_preview()) begin n_err++; $display("FAIL seed_zero_model: got %h want %h", preview, m_preview()); end
    for (int r = 0; r < 2; r++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
      tick(1'b0, 1'b1, 16'h1234, 1'b0);
      for (int i = 0; i < 20; i++) begin
        if (r == 0) run_a[i] = int'(piece); else run_b[i] = int'(piece);
        tick(1'b0, 1'b0, 16'h0, 1'b1);
      end
    end
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (run_a[i] != run_b[i]) begin n_err++; $display("FAIL seed_repeat %0d: got %0d want %0d", i, run_b[i], run_a[i]); end
    end
    n_cmp++; if (piece !== PW'(m_q[0])) begin n_err++; $display("FAIL seed_model_head: got %0d want %0d", piece, m_q[0]); end
  endtask

  task automatic test_midrun_reset();
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 16'h0, i > 3);
    tick(1'b1, 1'b0, 16'h0, 1'b1);
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", count); end
    n_cmp++; if (piece !== 3'd0) begin n_err++; $display("FAIL midrst_piece: got %0d want 0", piece); end
    n_cmp++; if (preview !== 9'd0) begin n_err++; $display("FAIL midrst_preview: got %h want 0", preview); end
    n_cmp++; if (piece_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", piece_valid); end
  endtask

`ifdef PIECE_GEN_BAG_EN
  task automatic test_bag();
    logic [NP-1:0] seen;
    bit            bad_code;
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
    for (int b = 0; b < 100; b++) begin
      seen = '0; bad_code = 1'b0;
      for (int i = 0; i < NP; i++) begin
        if (piece == 3'd0 || piece > 3'd7) bad_code = 1'b1;
        else if (seen[piece-1]) bad_code = 1'b1;
        else seen[piece-1] = 1'b1;
        tick(1'b0, 1'b0, 16'h0, 1'b1);
      end
      n_cmp++;
      if (bad_code || seen !== 7'h7F) begin n_err++; $display("FAIL bag %0d: got mask %h want 7f", b, seen); end
    end
  endtask
`else
  task automatic test_nobag();
    int out_of_range = 0;
    int repeats = 0;
    int prev = -1;
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (piece == 3'd0 || piece > 3'd7) out_of_range++;
      if (int'(piece) == prev) repeats++;
      prev = int'(piece);
      tick(1'b0, 1'b0, 16'h0, 1'b1);
    end
    n_cmp++; if (out_of_range != 0) begin n_err++; $display("FAIL nobag_range: got %0d bad want 0", out_of_range); end
    n_cmp++; if (repeats == 0) begin n_err++; $display("FAIL nobag_repeat: got %0d repeats want >0", repeats); end
    n_cmp++; if (piece !== PW'(m_q[0])) begin n_err++; $display("FAIL nobag_model: got %0d want %0d", piece, m_q[0]); end
  endtask
`endif

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed = 16'h0; next_req = 1'b0;
    test_reset();
    test_fill();
    test_empty_req();
    test_back_to_back();
    test_seed();
    test_midrun_reset();
`ifdef PIECE_GEN_BAG_EN
    test_bag();
`else
    test_nobag();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
